// File: rtl/cpu_reset_sequencer.sv
// Reset source for the mips core: turns the board's async active-low reset into a
// stretched synchronous active-high cpu_reset and services req/ack soft resets.
module cpu_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int SOFT_HOLD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_req,
  output logic       soft_ack,
  output logic       cpu_reset,
  output logic       por_done,
  output logic [1:0] reset_cause,
  output logic [7:0] soft_count
);

  localparam int MAX_HOLD = (HOLD_CYCLES > SOFT_HOLD) ? HOLD_CYCLES : SOFT_HOLD;
  localparam int CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_HOLD - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RUN,
    ST_SOFT
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-2:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_armed;
  logic                   r_soft_ack;
  logic                   r_cpu_reset;
  logic                   r_por_done;
  logic [1:0]             r_cause;
  logic [7:0]             r_soft_count;

  // The ASSERT->HOLD transition acts as the final synchronizer stage, so the
  // explicit shift register is one bit shorter than SYNC_STAGES.
  logic [SYNC_STAGES-1:0] w_sync_shift;
  logic                   w_sync_rel;

  assign w_sync_shift = {r_sync, 1'b1};
  assign w_sync_rel   = w_sync_shift[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ASSERT;
      r_sync       <= '0;
      r_cnt        <= '0;
      r_armed      <= 1'b1;
      r_soft_ack   <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_por_done   <= 1'b0;
      r_cause      <= 2'b01;
      r_soft_count <= 8'd0;
    end else begin
      r_sync     <= w_sync_shift[SYNC_STAGES-2:0];
      r_soft_ack <= 1'b0;
      // Any low sample re-arms, regardless of state.
      if (!soft_req) r_armed <= 1'b1;
      case (r_state)
        ST_ASSERT: begin
          if (w_sync_rel) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state     <= ST_RUN;
            r_cpu_reset <= 1'b0;
            r_por_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (soft_req && r_armed) begin
            r_state     <= ST_SOFT;
            r_cpu_reset <= 1'b1;
            r_cause     <= 2'b10;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            if (r_soft_count != 8'hFF) r_soft_count <= r_soft_count + 8'd1;
          end
        end
        ST_SOFT: begin
          if (r_cnt == SOFT_LAST) begin
            r_state     <= ST_RUN;
            r_cpu_reset <= 1'b0;
            r_soft_ack  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_ASSERT;
          r_cpu_reset <= 1'b1;
        end
      endcase
    end
  end

  assign soft_ack    = r_soft_ack;
  assign cpu_reset   = r_cpu_reset;
  assign por_done    = r_por_done;
  assign reset_cause = r_cause;
  assign soft_count  = r_soft_count;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Directed bench for cpu_reset_sequencer: power-on timing, soft reset handshakes,
// saturation, asynchronous abort and requests held through HOLD.
module tb_cpu_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       soft_req;
  logic       soft_ack;
  logic       cpu_reset;
  logic       por_done;
  logic [1:0] reset_cause;
  logic [7:0] soft_count;

  int n_checks;
  int n_errors;

  cpu_reset_sequencer #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(10),
    .SOFT_HOLD  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_req   (soft_req),
    .soft_ack   (soft_ack),
    .cpu_reset  (cpu_reset),
    .por_done   (por_done),
    .reset_cause(reset_cause),
    .soft_count (soft_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checks the 12-edge release sequence; reset must already be low.
  task automatic release_sequence(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (cpu_reset !== (k < 12)) begin
        n_errors++;
        $display("FAIL %s cpu_reset edge %0d: got %b want %b", tag, k, cpu_reset, (k < 12));
      end
      n_checks++;
      if (por_done !== (k >= 12)) begin
        n_errors++;
        $display("FAIL %s por_done edge %0d: got %b want %b", tag, k, por_done, (k >= 12));
      end
      n_checks++;
      if (reset_cause !== 2'b01 || soft_count !== 8'd0 || soft_ack !== 1'b0) begin
        n_errors++;
        $display("FAIL %s status edge %0d: cause=%b count=%0d ack=%b want 01/0/0",
                 tag, k, reset_cause, soft_count, soft_ack);
      end
    end
    $display("%s: release sequence done, cpu_reset=%b por_done=%b", tag, cpu_reset, por_done);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    soft_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cpu_reset !== 1'b1 || por_done !== 1'b0 || soft_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: cpu_reset=%b por_done=%b ack=%b want 1/0/0",
               cpu_reset, por_done, soft_ack);
    end
    n_checks++;
    if (reset_cause !== 2'b01 || soft_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_cause_count: cause=%b count=%0d want 01/0", reset_cause, soft_count);
    end
    release_sequence("power_on");
  endtask

  task automatic test_soft_pulse();
    @(negedge clk);
    soft_req = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (cpu_reset !== 1'b1 || reset_cause !== 2'b10 || soft_count !== 8'd1 || soft_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL soft_enter: cpu_reset=%b cause=%b count=%0d ack=%b want 1/10/1/0",
               cpu_reset, reset_cause, soft_count, soft_ack);
    end
    @(negedge clk);
    soft_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (cpu_reset !== (k < 4)) begin
        n_errors++;
        $display("FAIL soft_hold cpu_reset e+%0d: got %b want %b", k, cpu_reset, (k < 4));
      end
      n_checks++;
      if (soft_ack !== (k == 4)) begin
        n_errors++;
        $display("FAIL soft_ack e+%0d: got %b want %b", k, soft_ack, (k == 4));
      end
    end
    n_checks++;
    if (por_done !== 1'b1 || reset_cause !== 2'b10) begin
      n_errors++;
      $display("FAIL soft_sticky: por_done=%b cause=%b want 1/10", por_done, reset_cause);
    end
    $display("soft pulse: count=%0d cause=%b", soft_count, reset_cause);
  endtask

  task automatic test_held_request();
    int acks;
    int high_cycles;
    acks = 0;
    high_cycles = 0;
    @(negedge clk);
    soft_req = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (soft_ack) acks++;
      if (cpu_reset) high_cycles++;
    end
    n_checks++;
    if (acks !== 1 || high_cycles !== 4) begin
      n_errors++;
      $display("FAIL held_single: acks=%0d reset_cycles=%0d want 1/4", acks, high_cycles);
    end
    n_checks++;
    if (soft_count !== 8'd2) begin
      n_errors++;
      $display("FAIL held_count: got %0d want 2", soft_count);
    end
    @(negedge clk);
    soft_req = 1'b0;
    @(negedge clk);
    soft_req = 1'b1;
    acks = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (soft_ack) acks++;
    end
    @(negedge clk);
    soft_req = 1'b0;
    n_checks++;
    if (acks !== 1 || soft_count !== 8'd3) begin
      n_errors++;
      $display("FAIL rearm: acks=%0d count=%0d want 1/3", acks, soft_count);
    end
    $display("held request: count=%0d", soft_count);
  endtask

  task automatic test_saturation();
    int exp_count;
    bit got;
    exp_count = 3;
    for (int h = 0; h < 260; h++) begin
      @(negedge clk);
      soft_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      soft_req = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 10; w++) begin
        @(posedge clk);
        #1;
        if (soft_ack) begin
          got = 1'b1;
          break;
        end
      end
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      n_checks++;
      if (!got || soft_count !== 8'(exp_count)) begin
        n_errors++;
        $display("FAIL handshake %0d: ack=%b count=%0d want ack=1 count=%0d",
                 h, got, soft_count, exp_count);
      end
      $display("handshake %0d: count=%0d", h, soft_count);
    end
    n_checks++;
    if (soft_count !== 8'd255) begin
      n_errors++;
      $display("FAIL saturate: got %0d want 255", soft_count);
    end
  endtask

  task automatic test_async_abort();
    @(negedge clk);
    soft_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    soft_req = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (cpu_reset !== 1'b1 || soft_count !== 8'd0 || reset_cause !== 2'b01 || por_done !== 1'b0) begin
      n_errors++;
      $display("FAIL async_abort: cpu_reset=%b count=%0d cause=%b por_done=%b want 1/0/01/0",
               cpu_reset, soft_count, reset_cause, por_done);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (soft_ack !== 1'b0 || cpu_reset !== 1'b1) begin
        n_errors++;
        $display("FAIL abort_no_ack cycle %0d: ack=%b cpu_reset=%b want 0/1", k, soft_ack, cpu_reset);
      end
    end
    $display("async abort: reset held");
    release_sequence("after_abort");
  endtask

  task automatic test_hold_ignore();
    int acks;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    soft_req = 1'b1;
    release_sequence("hold_ignore");
    @(posedge clk);
    #1;
    n_checks++;
    if (cpu_reset !== 1'b1 || reset_cause !== 2'b10 || soft_count !== 8'd1) begin
      n_errors++;
      $display("FAIL hold_taken: cpu_reset=%b cause=%b count=%0d want 1/10/1",
               cpu_reset, reset_cause, soft_count);
    end
    acks = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (soft_ack) acks++;
    end
    n_checks++;
    if (acks !== 1 || soft_count !== 8'd1 || cpu_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_once: acks=%0d count=%0d cpu_reset=%b want 1/1/0",
               acks, soft_count, cpu_reset);
    end
    @(negedge clk);
    soft_req = 1'b0;
    $display("hold ignore: count=%0d", soft_count);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    soft_req = 1'b0;
    test_reset();
    test_soft_pulse();
    test_held_request();
    test_saturation();
    test_async_abort();
    test_hold_ignore();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
